// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 4-digit common-anode seven-segment driver.
// Scans one digit per SCAN_DIV cycles and snapshots the four BCD inputs once
// per frame, so a frame never mixes old and new values. Supports per-digit
// blink masking and a colon on digit 2's decimal point.
// Optional build macro: SEG7_LZB_EN enables leading-zero blanking of digit 3.
module seg7_scan_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 62
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hh_t,
    input  logic [3:0] hh_u,
    input  logic [3:0] mm_t,
    input  logic [3:0] mm_u,
    input  logic [3:0] blink_mask,
    input  logic       colon_on,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [3:0] an_n,
    output logic       frame_start
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low {g,f,e,d,c,b,a} pattern for one BCD value; 10..15 show a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // run_q holds the scan off for one cycle after reset release so the
    // first enabled digit lands on the second edge and gets its full slot.
    logic                 run_q;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [1:0]           idx_q, idx_d;
    logic [3:0]           sh_q [4];
    logic [FRM_W-1:0]     frm_cnt_q, frm_cnt_d;
    logic                 blink_phase_q, blink_phase_d;
    logic                 tick, frame_end;

    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic [3:0]           an_q, an_d;
    logic                 fs_q;

    logic [3:0]           digit;
    logic                 blanked;
    logic                 lzb_blank;

    // Prescaler, digit index and blink frame counter next-state.
    always_comb begin
        tick          = run_q && (div_cnt_q == DIV_LAST);
        frame_end     = tick && (idx_q == 2'd3);
        div_cnt_d     = div_cnt_q;
        idx_d         = idx_q;
        frm_cnt_d     = frm_cnt_q;
        blink_phase_d = blink_phase_q;
        if (run_q) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        end
        if (tick) begin
            idx_d = idx_q + 2'd1;
        end
        if (frame_end) begin
            if (frm_cnt_q == FRM_LAST) begin
                frm_cnt_d     = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frm_cnt_d = frm_cnt_q + 1'b1;
            end
        end
    end

    // Control state and per-frame input snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q         <= 1'b0;
            div_cnt_q     <= '0;
            idx_q         <= 2'd0;
            frm_cnt_q     <= '0;
            blink_phase_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                sh_q[i] <= 4'd0;
            end
        end else begin
            run_q         <= 1'b1;
            div_cnt_q     <= div_cnt_d;
            idx_q         <= idx_d;
            frm_cnt_q     <= frm_cnt_d;
            blink_phase_q <= blink_phase_d;
            if (frame_end) begin
                sh_q[3] <= hh_t;
                sh_q[2] <= hh_u;
                sh_q[1] <= mm_t;
                sh_q[0] <= mm_u;
            end
        end
    end

    // Segment, decimal point and anode values for the current digit slot.
    always_comb begin
        digit   = sh_q[idx_q];
        blanked = blink_mask[idx_q] && blink_phase_q;
`ifdef SEG7_LZB_EN
        lzb_blank = (idx_q == 2'd3) && (sh_q[3] == 4'd0);
`else
        lzb_blank = 1'b0;
`endif
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        an_d  = 4'b1111;
        if (run_q) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = (blanked || lzb_blank) ? SEG_BLANK : bcd_to_seg(digit);
            dp_d  = ~((idx_q == 2'd2) && colon_on && !blanked);
        end
    end

    // Output registers: segments and enables switch on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
            an_q  <= 4'b1111;
            fs_q  <= 1'b0;
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
            fs_q  <= frame_end;
        end
    end

    assign seg_n       = seg_q;
    assign dp_n        = dp_q;
    assign an_n        = an_q;
    assign frame_start = fs_q;

endmodule
